// File: rtl/dmem_access_unit.sv
// dmem_access_unit: memory-stage bridge from the pipelined datapath to a
// single-beat, word-aligned data-memory bus with byte enables.
// Optional feature: define DMEM_TIMEOUT_EN to abandon a bus access after
// TIMEOUT wait cycles. The abandoned access pulses BusErr and a timed-out load returns 0.
module dmem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [1:0]  SizeM,
  input  logic        SignedM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallMem,
  output logic        MisalignM,
  output logic        BusErr,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [3:0]  BusByteEn,
  output logic [31:0] BusWData,
  input  logic [31:0] BusRData,
  input  logic        BusAck
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic        bus_err_q, bus_err_d;
  // Access attributes kept for load extraction once the M-stage inputs move on
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // TIMEOUT only matters when the watchdog is built in
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  logic        aligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Alignment check plus lane enables and replicated store data for the request
  always_comb begin
    aligned   = 1'b1;
    req_be    = 4'b1111;
    req_wdata = WriteDataM;
    case (SizeM)
      2'b00: begin
        req_be    = 4'b0001 << ALUResultM[1:0];
        req_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        aligned   = ~ALUResultM[0];
        req_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        aligned = (ALUResultM[1:0] == 2'b00);
      end
    endcase
  end

  // Pick the addressed lane out of the bus word and extend it
  always_comb begin
    case (lane_q)
      2'd0:    load_byte = BusRData[7:0];
      2'd1:    load_byte = BusRData[15:8];
      2'd2:    load_byte = BusRData[23:16];
      default: load_byte = BusRData[31:24];
    endcase
    load_half = lane_q[1] ? BusRData[31:16] : BusRData[15:0];
    case (size_q)
      2'b00:   load_data = {{24{signed_q & load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{signed_q & load_half[15]}}, load_half};
      default: load_data = BusRData;
    endcase
  end

  // Next-state and next-register values for the access FSM
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    read_data_d = read_data_q;
    bus_err_d   = 1'b0;
    size_d      = size_q;
    signed_d    = signed_q;
    lane_d      = lane_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (MemReqM && aligned) begin
          state_d     = ST_WAIT;
          bus_req_d   = 1'b1;
          bus_we_d    = MemWriteM;
          bus_addr_d  = {ALUResultM[31:2], 2'b00};
          bus_be_d    = req_be;
          bus_wdata_d = req_wdata;
          size_d      = SizeM;
          signed_d    = SignedM;
          lane_d      = ALUResultM[1:0];
`ifdef DMEM_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (BusAck) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          if (!bus_we_q) read_data_d = load_data;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          bus_err_d = 1'b1;
          if (!bus_we_q) read_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      read_data_q <= '0;
      bus_err_q   <= 1'b0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      lane_q      <= '0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      read_data_q <= read_data_d;
      bus_err_q   <= bus_err_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign StallMem  = reset & (((state_q == ST_IDLE) & MemReqM & aligned) | (state_q == ST_WAIT));
  assign MisalignM = reset & (state_q == ST_IDLE) & MemReqM & ~aligned;
  assign ReadDataM = read_data_q;
  assign BusErr    = bus_err_q;
  assign BusReq    = bus_req_q;
  assign BusWe     = bus_we_q;
  assign BusAddr   = bus_addr_q;
  assign BusByteEn = bus_be_q;
  assign BusWData  = bus_wdata_q;

endmodule
